// File: rtl/lsu_dmem_ctrl.sv
// Data-memory control for the load/store unit: two-cycle load sequencing,
// store lane alignment and load extraction against a 1-cycle-latency SRAM.
module lsu_dmem_ctrl #(
  parameter int unsigned ADDR_W        = 14,
  parameter logic [31:0] RST_LOAD_DATA = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic [3:0]        MemWrite,
  input  logic [2:0]        Func3,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       rs2_data,
  input  logic [31:0]       dm_do,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_oe,
  output logic [3:0]        dm_web,
  output logic [31:0]       dm_di,
  output logic [1:0]        counter02,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              misalign_err
);

  typedef enum logic {IDLE, LD_DATA} state_t;

  state_t      state, state_nxt;
  logic [1:0]  k_q;
  logic [2:0]  f3_q;
  logic [31:0] load_q;
  logic [31:0] sh;
  logic [31:0] ext_data;
  logic        ext_err;

  assign dm_addr = data_addr[ADDR_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      load_q <= RST_LOAD_DATA;
      k_q    <= '0;
      f3_q   <= '0;
    end else begin
      state <= state_nxt;
      // Offset and width are captured with the request so later address
      // changes cannot disturb extraction in the data phase.
      if (state == IDLE && MemRead) begin
        k_q  <= data_addr[1:0];
        f3_q <= Func3;
      end
      if (state == LD_DATA) load_q <= ext_data;
    end
  end

  always_comb begin
    sh       = dm_do >> {k_q, 3'b000};
    ext_data = '0;
    ext_err  = 1'b0;
    case (f3_q)
      3'b000: ext_data = {{24{sh[7]}}, sh[7:0]};
      3'b001: begin
        if (k_q == 2'd3) ext_err = 1'b1;
        else             ext_data = {{16{sh[15]}}, sh[15:0]};
      end
      3'b010: begin
        if (k_q != 2'd0) ext_err = 1'b1;
        else             ext_data = dm_do;
      end
      3'b100: ext_data = {24'h0, sh[7:0]};
      3'b101: begin
        if (k_q == 2'd3) ext_err = 1'b1;
        else             ext_data = {16'h0, sh[15:0]};
      end
      default: ext_err = 1'b1;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    dm_oe        = 1'b0;
    dm_web       = '0;
    dm_di        = '0;
    counter02    = 2'd0;
    stall        = 1'b0;
    load_data    = load_q;
    misalign_err = 1'b0;
    if (rst) begin
      state_nxt = IDLE;
      load_data = RST_LOAD_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (MemRead) begin
            dm_oe     = 1'b1;
            stall     = 1'b1;
            state_nxt = LD_DATA;
          end else begin
            dm_web       = {MemWrite[0], MemWrite[1], MemWrite[2], MemWrite[3]};
            dm_di        = rs2_data << {data_addr[1:0], 3'b000};
            misalign_err = (MemWrite == 4'b0000) && (Func3 <= 3'b010) &&
                           (data_addr != 32'h0);
          end
        end
        LD_DATA: begin
          counter02    = 2'd1;
          load_data    = ext_data;
          misalign_err = ext_err;
          state_nxt    = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
